// File: rtl/prod_accum.sv
// prod_accum: sums LEN unsigned products into a width+GUARD bit
// accumulator with a sticky carry-out flag.
//
// Ports:
//   CLK, RST_N       clock, async active-low reset
//   START, LEN       job request and product count (taken in IDLE)
//   P, P_VALID       product stream in, P_READY high while in ACCUM
//   ACC, OVF         running/final sum and sticky overflow flag
//   R_VALID, R_READY result handshake, R_VALID high while in DONE
//   BUSY             high in ACCUM or DONE
//
// Define PROD_ACCUM_SAT_EN to saturate ACC to all-ones on overflow;
// without it ACC wraps modulo 2^AW. OVF is set either way.
module prod_accum #(
  parameter int width = 32,
  parameter int GUARD = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [7:0]             LEN,
  input  logic [width-1:0]       P,
  input  logic                   P_VALID,
  output logic                   P_READY,
  output logic [width+GUARD-1:0] ACC,
  output logic                   R_VALID,
  input  logic                   R_READY,
  output logic                   OVF,
  output logic                   BUSY
);

  localparam int AW = width + GUARD;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic [AW-1:0] acc;
  logic          ovf;
  logic [AW:0]   sum;
  logic          carry;
  logic          take;
  logic          start_ok;

  // One extra bit on the adder captures the carry out of bit AW-1.
  assign sum   = {1'b0, acc} + {{(GUARD + 1){1'b0}}, P};
  assign carry = sum[AW];

  assign take     = (state == ACCUM) && P_VALID;
  assign start_ok = (state == IDLE) && START;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (START)
          state_nxt = (LEN != 8'd0) ? ACCUM : DONE;
      end
      ACCUM: begin
        if (P_VALID && cnt == 8'd1)
          state_nxt = DONE;
      end
      DONE: begin
        if (R_READY)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        cnt <= LEN;
        acc <= '0;
        ovf <= 1'b0;
      end else if (take) begin
        cnt <= cnt - 8'd1;
        ovf <= ovf | carry;
`ifdef PROD_ACCUM_SAT_EN
        // Once saturated, stay pinned for the rest of the job.
        if (carry || ovf)
          acc <= '1;
        else
          acc <= sum[AW-1:0];
`else
        acc <= sum[AW-1:0];
`endif
      end
    end
  end

  assign P_READY = (state == ACCUM);
  assign R_VALID = (state == DONE);
  assign BUSY    = (state != IDLE);
  assign ACC     = acc;
  assign OVF     = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: table-driven jobs plus hand sequences for stalls,
// reset abort, back-to-back jobs and overflow on a GUARD=1 instance.
module tb_prod_accum;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [7:0]  len;
  logic [31:0] p;
  logic        p_valid;
  logic        p_ready;
  logic [39:0] acc;
  logic        r_valid;
  logic        r_ready;
  logic        ovf;
  logic        busy;

  logic        g_start;
  logic [7:0]  g_len;
  logic [31:0] g_p;
  logic        g_p_valid;
  logic        g_p_ready;
  logic [32:0] g_acc;
  logic        g_r_valid;
  logic        g_r_ready;
  logic        g_ovf;
  logic        g_busy;

  int passed;
  int total;

  typedef struct {
    logic [39:0] acc;
    logic        ovf;
  } res_t;

  res_t sbq[$];

  typedef struct {
    int              n;
    logic [3:0][31:0] ps;
    int              gap;
    logic [39:0]     exp_acc;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[4];

  prod_accum u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(start), .LEN(len),
    .P(p), .P_VALID(p_valid), .P_READY(p_ready),
    .ACC(acc), .R_VALID(r_valid), .R_READY(r_ready),
    .OVF(ovf), .BUSY(busy)
  );

  prod_accum #(.width(32), .GUARD(1)) u_g1 (
    .CLK(CLK), .RST_N(RST_N), .START(g_start), .LEN(g_len),
    .P(g_p), .P_VALID(g_p_valid), .P_READY(g_p_ready),
    .ACC(g_acc), .R_VALID(g_r_valid), .R_READY(g_r_ready),
    .OVF(g_ovf), .BUSY(g_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for a result (bounded), then pop and compare.
  task automatic take_result(input string name);
    res_t e;
    int   k;
    k = 0;
    while (!r_valid && k < 50) begin
      tick();
      k++;
    end
    check({name, "_rvalid"}, 64'(r_valid), 64'd1);
    if (sbq.size() == 0) begin
      check({name, "_sbq"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      check({name, "_acc"}, 64'(acc), 64'(e.acc));
      check({name, "_ovf"}, 64'(ovf), 64'(e.ovf));
    end
  endtask

  task automatic handshake(input string name);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check({name, "_idle"}, 64'({r_valid, busy}), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    res_t r;
    r.acc = v.exp_acc;
    r.ovf = v.exp_ovf;
    start = 1'b1;
    len   = 8'(v.n);
    tick();
    start = 1'b0;
    sbq.push_back(r);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          p_valid = 1'b0;
          p       = 32'hDEAD_BEEF;
          tick();
        end
      end
      check({name, "_pready"}, 64'(p_ready), 64'd1);
      p       = v.ps[i];
      p_valid = 1'b1;
      tick();
    end
    p_valid = 1'b0;
    check({name, "_lat"}, 64'(r_valid), 64'd1);
    take_result(name);
    handshake(name);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    RST_N     = 1'b0;
    start     = 1'b0;
    len       = '0;
    p         = '0;
    p_valid   = 1'b0;
    r_ready   = 1'b0;
    g_start   = 1'b0;
    g_len     = '0;
    g_p       = '0;
    g_p_valid = 1'b0;
    g_r_ready = 1'b0;

    vecs[0] = '{3, {32'd0, 32'd9, 32'd7, 32'd5}, 0,
                40'd21, 1'b0};
    vecs[1] = '{1, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 0,
                40'hFF_FFFF_FFFF & 40'h00_FFFF_FFFF, 1'b0};
    vecs[2] = '{4, {32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1,
                40'h03_FFFF_FFFC, 1'b0};
    vecs[3] = '{2, {32'd0, 32'd0, 32'h20, 32'h10}, 3,
                40'h30, 1'b0};

    #2;
    check("rst_out", 64'({p_ready, r_valid, busy, ovf}), 64'd0);
    check("rst_acc", 64'(acc), 64'd0);
    tick();
    RST_N = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // LEN=0 after a nonzero job: ACC clears, straight to DONE.
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    sbq.push_back('{40'd0, 1'b0});
    check("len0_pready", 64'(p_ready), 64'd0);
    check("len0_lat", 64'(r_valid), 64'd1);
    take_result("len0");
    handshake("len0");

    // Stalls, START ignored in ACCUM/DONE, result held with R_READY low.
    start = 1'b1;
    len   = 8'd2;
    tick();
    start = 1'b0;
    sbq.push_back('{40'h30, 1'b0});
    p       = 32'h10;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start = (g == 1);
      len   = 8'd0;
      tick();
    end
    start = 1'b0;
    check("stall_acc", 64'(acc), 64'h10);
    check("stall_busy", 64'({busy, p_ready, r_valid}), 64'b110);
    p       = 32'h20;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    take_result("stall");
    for (int c = 0; c < 5; c++) begin
      start   = (c == 2);
      p_valid = (c == 3);
      tick();
      check("hold_acc", 64'(acc), 64'h30);
      check("hold_st", 64'({r_valid, p_ready}), 64'b10);
    end
    start   = 1'b0;
    p_valid = 1'b0;
    handshake("stall");
    check("idle_keep", 64'(acc), 64'h30);

    // Reset in the middle of a job aborts it.
    start = 1'b1;
    len   = 8'd4;
    tick();
    start   = 1'b0;
    p       = 32'd100;
    p_valid = 1'b1;
    tick();
    tick();
    p_valid = 1'b0;
    check("pre_rst_acc", 64'(acc), 64'd200);
    #2;
    RST_N = 1'b0;
    #1;
    check("abort_out", 64'({p_ready, r_valid, busy, ovf}), 64'd0);
    check("abort_acc", 64'(acc), 64'd0);
    tick();
    RST_N = 1'b1;
    run_vec('{1, {32'd0, 32'd0, 32'd0, 32'd7}, 0, 40'd7, 1'b0},
            "post_rst");

    // Back-to-back: START in the first IDLE cycle.
    start = 1'b1;
    len   = 8'd1;
    tick();
    start   = 1'b0;
    sbq.push_back('{40'd3, 1'b0});
    p       = 32'd3;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    take_result("b2b1");
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    start   = 1'b1;
    len     = 8'd1;
    tick();
    start   = 1'b0;
    sbq.push_back('{40'd4, 1'b0});
    check("b2b_accept", 64'(p_ready), 64'd1);
    p       = 32'd4;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    take_result("b2b2");
    handshake("b2b2");

    // GUARD=1 overflow.
    g_start = 1'b1;
    g_len   = 8'd3;
    tick();
    g_start   = 1'b0;
    g_p       = 32'hFFFF_FFFF;
    g_p_valid = 1'b1;
    tick();
    check("g1_ovf_first", 64'(g_ovf), 64'd0);
    tick();
    tick();
    g_p_valid = 1'b0;
    check("g1_rvalid", 64'(g_r_valid), 64'd1);
    check("g1_ovf", 64'(g_ovf), 64'd1);
`ifdef PROD_ACCUM_SAT_EN
    check("g1_acc", 64'(g_acc), 64'h1_FFFF_FFFF);
`else
    check("g1_acc", 64'(g_acc), 64'h0_FFFF_FFFD);
`endif
    g_r_ready = 1'b1;
    tick();
    g_r_ready = 1'b0;
    check("g1_idle_ovf", 64'(g_ovf), 64'd1);
    g_start = 1'b1;
    g_len   = 8'd1;
    tick();
    g_start = 1'b0;
    check("g1_restart", 64'({g_ovf, g_acc}), 64'd0);
    g_p       = 32'd2;
    g_p_valid = 1'b1;
    tick();
    g_p_valid = 1'b0;
    check("g1_small", 64'(g_acc), 64'd2);
    check("g1_small_ovf", 64'(g_ovf), 64'd0);

    check("sbq_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
